hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central pipeline sequencer driving the stall/flush controls of PC, IF/ID and ID/EX.
//  Detects load-use hazards and taken branches/jumps; holds the front end during cache
//  misses and multi-cycle MUL/DIV. Sits beside the datapath; all pipeline regs consume its outputs.
//  Stall dominates flush: a flush raised during a stall is remembered and issued when the stall ends.
// PARAMETERS
//  MDU_CYCLES  32  cycles the MUL/DIV unit occupies EX after mdu_start (>=2)
//  CNT_W       6   width of MDU countdown counter; must hold MDU_CYCLES
// PORTS
//  clk             in   1   system clock; state updates on posedge (pipeline regs sample on negedge)
//  reset           in   1   asynchronous, active-low reset
//  ifid_rs_addr    in   `REG_ADDR_BUS  rs of instruction in ID
//  ifid_rt_addr    in   `REG_ADDR_BUS  rt of instruction in ID
//  idex_rt_addr    in   `REG_ADDR_BUS  destination of instruction in EX
//  idex_mem_read   in   1   EX instruction is a load
//  id_jump         in   1   ID decodes j/jal/jr (redirect next cycle)
//  ex_branch_taken in   1   EX resolves a taken branch
//  mdu_start       in   1   EX issues MUL/DIV this cycle
//  imem_ready      in   1   instruction fetch complete (0 = I-miss)
//  dmem_ready      in   1   data access complete (0 = D-miss)
//  cu_pc_stall     out  1   hold PC
//  cu_stall        out  1   hold IF/ID
//  cu_flush        out  1   clear IF/ID to nop (pc 0, pc_4 4, instr 0)
//  cu_idex_flush   out  1   insert bubble into ID/EX
//  cu_busy         out  1   FSM not in RUN
// BEHAVIOUR
//  Reset (reset==0, async): state=RUN, mdu_cnt=0, pend_flush=0; all outputs 0.
//  FSM states: RUN, MISS_WAIT, MDU_WAIT.
//   RUN->MISS_WAIT when !imem_ready || !dmem_ready; MISS_WAIT->RUN when both ready.
//   RUN->MDU_WAIT on mdu_start; mdu_cnt loads MDU_CYCLES-1, decrements each cycle;
//    MDU_WAIT->RUN when mdu_cnt==0. A miss during MDU_WAIT keeps counting; exit
//    from MDU_WAIT goes to MISS_WAIT if a miss is still pending.
//   mdu_start while already in MDU_WAIT: ignored (EX is frozen; cannot occur legally).
//  Load-use (combinational, RUN only): lu = idex_mem_read && idex_rt_addr!=0 &&
//   (idex_rt_addr==ifid_rs_addr || idex_rt_addr==ifid_rt_addr).
//  Output priority (highest first):
//   1 state!=RUN or miss pending: cu_pc_stall=cu_stall=1, cu_flush=0, cu_idex_flush=0.
//   2 lu: cu_pc_stall=cu_stall=1, cu_idex_flush=1, cu_flush=0. One cycle only.
//   3 ex_branch_taken or pend_flush: cu_flush=1, cu_idex_flush=1 (kill ID and wrong-path EX slot).
//   4 id_jump: cu_flush=1 only.
//   else all 0.
//  pend_flush: set on posedge when ex_branch_taken && stall active; cleared on the
//   posedge after cu_flush is issued. id_jump during stall is not latched (re-decoded).
//  cu_stall and cu_flush never both 1 (IF/ID ignores flush under stall; enforced here too).
//  Outputs are combinational from registered state + inputs, settled before negedge.
//  Reset mid-MDU/miss: counter and pending flush discarded; restart in RUN.
// STRUCTURE
//  common.vh: `REG_ADDR_BUS; add `HZ_RUN/`HZ_MISS/`HZ_MDU state codes (2 bits).
//  One sub-module natural: mdu_timer (load/decrement/zero flag, CNT_W wide).
//  FSM, load-use compare and output priority mux remain in hazard_ctrl.
// TESTING
//  ID rs=5, EX load rt=5 -> 1 cycle cu_stall=cu_pc_stall=cu_idex_flush=1, then all 0.
//  EX load rt=0, ID rs=0 -> no stall (r0 exempt).
//  mdu_start, MDU_CYCLES=4 -> cu_stall=1 exactly 4 cycles, cu_busy=1, back to RUN.
//  dmem_ready=0 for 3 cycles with ex_branch_taken in cycle 1 -> stall 3 cycles,
//   cu_flush=1 in cycle 4 only, pend_flush cleared after.
//  id_jump alone -> cu_flush=1, cu_idex_flush=0, no stall.
//  reset low during MDU_WAIT (cnt=10) -> outputs 0 immediately; RUN after release.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   reg_addr_t  : architectural register index
//   hz_state_e  : sequencer states (Run / MissWait / MduWait), 2-bit encoded
//   load_use()  : load-use hazard compare between the EX load and the ID operands
package hazard_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef logic [RegAddrW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMissWait = 2'd1,
    StMduWait  = 2'd2
  } hz_state_e;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use(logic mem_read, reg_addr_t ex_rt, reg_addr_t id_rs,
                                    reg_addr_t id_rt);
    return mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath and the hazard controller.
//   master : datapath side (drives hazard inputs, consumes stall/flush controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_addr_t ifid_rs_addr;
  reg_addr_t ifid_rt_addr;
  reg_addr_t idex_rt_addr;
  logic      idex_mem_read;
  logic      id_jump;
  logic      ex_branch_taken;
  logic      mdu_start;
  logic      imem_ready;
  logic      dmem_ready;

  logic      cu_pc_stall;
  logic      cu_stall;
  logic      cu_flush;
  logic      cu_idex_flush;
  logic      cu_busy;

  modport master (
    output ifid_rs_addr, ifid_rt_addr, idex_rt_addr, idex_mem_read, id_jump,
           ex_branch_taken, mdu_start, imem_ready, dmem_ready,
    input  cu_pc_stall, cu_stall, cu_flush, cu_idex_flush, cu_busy
  );

  modport slave (
    input  ifid_rs_addr, ifid_rt_addr, idex_rt_addr, idex_mem_read, id_jump,
           ex_branch_taken, mdu_start, imem_ready, dmem_ready,
    output cu_pc_stall, cu_stall, cu_flush, cu_idex_flush, cu_busy
  );

endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// Countdown timer for the multi-cycle MUL/DIV occupancy of EX.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load MduCycles-1 (takes priority over dec_i)
//   dec_i         : decrement while non-zero
//   zero_o        : counter is zero
module hazard_ctrl_mdu_timer #(
  parameter int unsigned MduCycles = 32,
  parameter int unsigned CntW      = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(MduCycles - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush controls for PC, IF/ID and ID/EX.
//   clk_i, rst_ni : clock (state on posedge), async active-low reset
//   bus (slave)   : hazard inputs from the datapath, cu_* controls back to it
// Stall dominates flush; a taken branch seen under stall is held in pend_flush_q
// and issued on the first unstalled cycle.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MduCycles = 32,
  parameter int unsigned CntW      = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  hazard_ctrl_if.slave bus
);

  hz_state_e state_q, state_d;
  logic      pend_flush_q, pend_flush_d;
  logic      miss, mdu_load, mdu_zero, hold, lu;
  logic      pc_stall, stall, flush, idex_flush;

  assign miss     = !bus.imem_ready || !bus.dmem_ready;
  assign mdu_load = (state_q == StRun) && bus.mdu_start;
  // MissWait releases the front end in the same cycle both memories report ready;
  // the state itself returns to Run on the following edge.
  assign hold     = (state_q == StMduWait) || miss;
  assign lu       = !hold && load_use(bus.idex_mem_read, bus.idex_rt_addr,
                                      bus.ifid_rs_addr, bus.ifid_rt_addr);

  hazard_ctrl_mdu_timer #(
    .MduCycles (MduCycles),
    .CntW      (CntW)
  ) u_mdu_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (mdu_load),
    .dec_i  (state_q == StMduWait),
    .zero_o (mdu_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (bus.mdu_start) begin
          state_d = StMduWait;
        end else if (miss) begin
          state_d = StMissWait;
        end
      end
      StMissWait: if (!miss) state_d = StRun;
      StMduWait:  if (mdu_zero) state_d = miss ? StMissWait : StRun;
      default:    state_d = StRun;
    endcase
  end

  always_comb begin
    pc_stall   = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    idex_flush = 1'b0;
    if (hold) begin
      pc_stall = 1'b1;
      stall    = 1'b1;
    end else if (lu) begin
      pc_stall   = 1'b1;
      stall      = 1'b1;
      idex_flush = 1'b1;
    end else if (bus.ex_branch_taken || pend_flush_q) begin
      flush      = 1'b1;
      idex_flush = 1'b1;
    end else if (bus.id_jump) begin
      flush = 1'b1;
    end
  end

  always_comb begin
    pend_flush_d = pend_flush_q;
    if (flush) begin
      pend_flush_d = 1'b0;
    end else if (bus.ex_branch_taken && stall) begin
      pend_flush_d = 1'b1;
    end
  end

  // Controls are forced low while reset is held, independent of the inputs.
  assign bus.cu_pc_stall   = rst_ni && pc_stall;
  assign bus.cu_stall      = rst_ni && stall;
  assign bus.cu_flush      = rst_ni && flush;
  assign bus.cu_idex_flush = rst_ni && idex_flush;
  assign bus.cu_busy       = rst_ni && (state_q != StRun);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Output vectors are {pc_stall, stall, flush, idex_flush, busy}.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl_if bus4 ();
  hazard_ctrl_if bus32 ();

  // Second DUT (default 32-cycle MDU) sees the same stimulus.
  assign bus32.ifid_rs_addr    = bus4.ifid_rs_addr;
  assign bus32.ifid_rt_addr    = bus4.ifid_rt_addr;
  assign bus32.idex_rt_addr    = bus4.idex_rt_addr;
  assign bus32.idex_mem_read   = bus4.idex_mem_read;
  assign bus32.id_jump         = bus4.id_jump;
  assign bus32.ex_branch_taken = bus4.ex_branch_taken;
  assign bus32.mdu_start       = bus4.mdu_start;
  assign bus32.imem_ready      = bus4.imem_ready;
  assign bus32.dmem_ready      = bus4.dmem_ready;

  hazard_ctrl #(
    .MduCycles (4),
    .CntW      (3)
  ) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus4)
  );

  hazard_ctrl u_dut32 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  function automatic logic [4:0] outs4();
    return {bus4.cu_pc_stall, bus4.cu_stall, bus4.cu_flush, bus4.cu_idex_flush, bus4.cu_busy};
  endfunction

  function automatic logic [4:0] outs32();
    return {bus32.cu_pc_stall, bus32.cu_stall, bus32.cu_flush, bus32.cu_idex_flush,
            bus32.cu_busy};
  endfunction

  task automatic set_idle();
    bus4.ifid_rs_addr    = '0;
    bus4.ifid_rt_addr    = '0;
    bus4.idex_rt_addr    = '0;
    bus4.idex_mem_read   = 1'b0;
    bus4.id_jump         = 1'b0;
    bus4.ex_branch_taken = 1'b0;
    bus4.mdu_start       = 1'b0;
    bus4.imem_ready      = 1'b1;
    bus4.dmem_ready      = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    #2 check_val("reset_idle", 32'(outs4()), 32'b00000);
    bus4.id_jump    = 1'b1;
    bus4.dmem_ready = 1'b0;
    #1 check_val("reset_gated", 32'(outs4()), 32'b00000);
    do_reset();

    // Load-use on rs, then the bubble reaches EX.
    bus4.ifid_rs_addr = 5'd5; bus4.idex_rt_addr = 5'd5; bus4.idex_mem_read = 1'b1;
    #1 check_val("lu_rs", 32'(outs4()), 32'b11010);
    step(); bus4.idex_mem_read = 1'b0;
    #1 check_val("lu_after", 32'(outs4()), 32'b00000);
    // Load-use on rt.
    step(); set_idle();
    bus4.ifid_rt_addr = 5'd7; bus4.idex_rt_addr = 5'd7; bus4.idex_mem_read = 1'b1;
    #1 check_val("lu_rt", 32'(outs4()), 32'b11010);
    // r0 is exempt.
    step(); set_idle(); bus4.idex_mem_read = 1'b1;
    #1 check_val("lu_r0", 32'(outs4()), 32'b00000);
    // Jump, branch, and both.
    step(); set_idle(); bus4.id_jump = 1'b1;
    #1 check_val("jump", 32'(outs4()), 32'b00100);
    step(); set_idle(); bus4.ex_branch_taken = 1'b1;
    #1 check_val("branch", 32'(outs4()), 32'b00110);
    step(); bus4.id_jump = 1'b1;
    #1 check_val("branch_jump", 32'(outs4()), 32'b00110);

    // MDU: 4 stalled cycles after the issue cycle.
    do_reset(); bus4.mdu_start = 1'b1;
    #1 check_val("mdu_issue", 32'(outs4()), 32'b00000);
    step(); bus4.mdu_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_val($sformatf("mdu_wait%0d", i), 32'(outs4()), 32'b11001);
      step();
    end
    #1 check_val("mdu_done", 32'(outs4()), 32'b00000);
    step();
    #1 check_val("mdu_run", 32'(outs4()), 32'b00000);

    // D-miss for 3 cycles with a branch in cycle 1: flush deferred to cycle 4.
    do_reset(); bus4.dmem_ready = 1'b0; bus4.ex_branch_taken = 1'b1;
    #1 check_val("miss_c1", 32'(outs4()), 32'b11000);
    step(); bus4.ex_branch_taken = 1'b0;
    bus4.ifid_rs_addr = 5'd5; bus4.idex_rt_addr = 5'd5; bus4.idex_mem_read = 1'b1;
    #1 check_val("miss_c2_lu", 32'(outs4()), 32'b11001);
    step(); set_idle(); bus4.dmem_ready = 1'b0; bus4.id_jump = 1'b1;
    #1 check_val("miss_c3", 32'(outs4()), 32'b11001);
    step(); set_idle();
    #1 check_val("miss_c4_flush", 32'(outs4()), 32'b00111);
    step();
    #1 check_val("miss_c5_clear", 32'(outs4()), 32'b00000);

    // I-miss outlasting the MDU: exit goes to MissWait.
    do_reset(); bus4.mdu_start = 1'b1;
    #1 check_val("mdu_miss_issue", 32'(outs4()), 32'b00000);
    step(); bus4.mdu_start = 1'b0; bus4.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_val($sformatf("mdu_miss%0d", i), 32'(outs4()), 32'b11001);
      step();
    end
    #1 check_val("mdu_to_miss", 32'(outs4()), 32'b11001);
    step(); bus4.imem_ready = 1'b1;
    #1 check_val("miss_release", 32'(outs4()), 32'b00001);
    step();
    #1 check_val("miss_back_run", 32'(outs4()), 32'b00000);

    // Reset while the 32-cycle MDU counter sits at 10.
    do_reset(); bus4.mdu_start = 1'b1;
    step(); bus4.mdu_start = 1'b0;
    repeat (21) step();
    #1 check_val("mdu32_cnt10", 32'(outs32()), 32'b11001);
    rst_n = 1'b0;
    #1 check_val("mdu32_reset", 32'(outs32()), 32'b00000);
    step(); rst_n = 1'b1;
    #1 check_val("mdu32_release", 32'(outs32()), 32'b00000);
    step();
    #1 check_val("mdu32_run", 32'(outs32()), 32'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
